// File: rtl/stage_5_byte_buffer_pkg.sv
// stage_5_pkg: shared types and constants for the stage-5 output byte buffer.
// Ports: none (package).
package stage_5_pkg;

  localparam int unsigned S5_BITSTREAM_WIDTH  = 8;
  localparam int unsigned S5_FIFO_DEPTH       = 32;
  localparam int unsigned S5_PTR_WIDTH        = 5;
  localparam int unsigned S5_OCC_WIDTH        = S5_PTR_WIDTH + 1;
  localparam int unsigned S5_FLAG_WIDTH       = 3;
  localparam int unsigned MAX_BYTES_PER_CYCLE = 5;

  typedef logic [S5_BITSTREAM_WIDTH-1:0] s5_byte_t;

  // Frame state: waiting, accepting bytes, draining to the last byte, done pulse
  typedef enum logic [1:0] {
    S5_IDLE  = 2'd0,
    S5_RUN   = 2'd1,
    S5_DRAIN = 2'd2,
    S5_DONE  = 2'd3
  } s5_state_t;

endpackage

// File: rtl/stage_5_byte_buffer_if.sv
// stage_5_byte_buffer_if: stage-4 byte input bus plus byte-sink handshake.
// Signals: in_bit_1..in_bit_5 (in_bit_1 oldest), in_flag_bitstream (count 0-5),
//          in_flag_last, in_ready (sink), out_byte, out_valid, out_last.
// Modports: master = upstream/sink side, slave = buffer side.
interface stage_5_byte_buffer_if;
  import stage_5_pkg::*;

  s5_byte_t                 in_bit_1;
  s5_byte_t                 in_bit_2;
  s5_byte_t                 in_bit_3;
  s5_byte_t                 in_bit_4;
  s5_byte_t                 in_bit_5;
  logic [S5_FLAG_WIDTH-1:0] in_flag_bitstream;
  logic                     in_flag_last;
  logic                     in_ready;
  s5_byte_t                 out_byte;
  logic                     out_valid;
  logic                     out_last;

  modport master (
    output in_bit_1, in_bit_2, in_bit_3, in_bit_4, in_bit_5,
    output in_flag_bitstream, in_flag_last, in_ready,
    input  out_byte, out_valid, out_last
  );

  modport slave (
    input  in_bit_1, in_bit_2, in_bit_3, in_bit_4, in_bit_5,
    input  in_flag_bitstream, in_flag_last, in_ready,
    output out_byte, out_valid, out_last
  );

endinterface

// File: rtl/stage_5_byte_buffer_ring.sv
// s5_byte_ring: circular byte store with multi-byte write and single-byte read.
// Ports: clk, rst (sync, active-high), wr_count (bytes to store, already
//        validated), wr_bytes[0..4] (oldest first), pop, rd_data (head byte),
//        wr_ptr, rd_ptr, occupancy.
module s5_byte_ring
  import stage_5_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [S5_FLAG_WIDTH-1:0] wr_count,
  input  s5_byte_t                 wr_bytes [MAX_BYTES_PER_CYCLE],
  input  logic                     pop,
  output s5_byte_t                 rd_data,
  output logic [S5_PTR_WIDTH-1:0]  wr_ptr,
  output logic [S5_PTR_WIDTH-1:0]  rd_ptr,
  output logic [S5_OCC_WIDTH-1:0]  occupancy
);

  s5_byte_t mem [S5_FIFO_DEPTH];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      wr_ptr    <= wr_ptr + S5_PTR_WIDTH'(wr_count);
      if (pop) rd_ptr <= rd_ptr + S5_PTR_WIDTH'(1);
      occupancy <= occupancy + S5_OCC_WIDTH'(wr_count) - S5_OCC_WIDTH'(pop);
    end
  end

  // Byte k lands at wr_ptr+k; storage itself needs no reset
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < MAX_BYTES_PER_CYCLE; k++) begin
      if (k < 32'(wr_count)) mem[wr_ptr + S5_PTR_WIDTH'(k)] <= wr_bytes[k];
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/stage_5_byte_buffer.sv
// stage_5_byte_buffer: buffers 0-5 bytes/cycle from stage 4 and drains one
// byte/cycle to the bitstream sink, marking the frame's last byte.
// Ports: s5_clk, s5_reset (sync, active-high), bus (slave side of
//        stage_5_byte_buffer_if), out_done, out_almost_full, out_overflow,
//        out_flag_error, and out_total_bytes when S5_BYTE_COUNTER_EN is defined
//        (popped-byte counter; out_done then trails by one cycle).
module stage_5_byte_buffer
  import stage_5_pkg::*;
(
  input  logic                 s5_clk,
  input  logic                 s5_reset,
  stage_5_byte_buffer_if.slave bus,
  output logic                 out_done,
  output logic                 out_almost_full,
  output logic                 out_overflow,
  output logic                 out_flag_error
`ifdef S5_BYTE_COUNTER_EN
  ,
  output logic [31:0]          out_total_bytes
`endif
);

  localparam int unsigned SUM_W = S5_OCC_WIDTH + 1;

  s5_state_t                state_q, state_d;
  logic [S5_PTR_WIDTH-1:0]  last_ptr_q, last_ptr_d;
  logic [S5_PTR_WIDTH-1:0]  wr_ptr, rd_ptr;
  logic [S5_OCC_WIDTH-1:0]  occ;
  s5_byte_t                 rd_data;
  s5_byte_t                 in_bytes_c [MAX_BYTES_PER_CYCLE];
  logic [S5_FLAG_WIDTH-1:0] n_req_c, n_wr_c;
  logic [SUM_W-1:0]         occ_sum_c, occ_after_c;
  logic                     flag_bad_c, wr_state_c, fits_c, valid_c, pop_c;

  assign in_bytes_c[0] = bus.in_bit_1;
  assign in_bytes_c[1] = bus.in_bit_2;
  assign in_bytes_c[2] = bus.in_bit_3;
  assign in_bytes_c[3] = bus.in_bit_4;
  assign in_bytes_c[4] = bus.in_bit_5;

  s5_byte_ring u_ring (
    .clk       (s5_clk),
    .rst       (s5_reset),
    .wr_count  (n_wr_c),
    .wr_bytes  (in_bytes_c),
    .pop       (pop_c),
    .rd_data   (rd_data),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .occupancy (occ)
  );

  assign valid_c = (occ != '0) && (state_q != S5_DONE);
  assign pop_c   = valid_c && bus.in_ready;

  // Write admission: bad counts and writes outside IDLE/RUN become zero;
  // a write that would exceed capacity is dropped whole
  always_comb begin
    flag_bad_c  = bus.in_flag_bitstream > S5_FLAG_WIDTH'(MAX_BYTES_PER_CYCLE);
    wr_state_c  = (state_q == S5_IDLE) || (state_q == S5_RUN);
    n_req_c     = (flag_bad_c || !wr_state_c) ? '0 : bus.in_flag_bitstream;
    occ_sum_c   = SUM_W'(occ) + SUM_W'(n_req_c) - SUM_W'(pop_c);
    fits_c      = occ_sum_c <= SUM_W'(S5_FIFO_DEPTH);
    n_wr_c      = fits_c ? n_req_c : '0;
    occ_after_c = fits_c ? occ_sum_c : (SUM_W'(occ) - SUM_W'(pop_c));
  end

  // Frame FSM; wr_ptr+n-1 also yields wr_ptr-1 when nothing is written
  always_comb begin
    state_d    = state_q;
    last_ptr_d = last_ptr_q;
    unique case (state_q)
      S5_IDLE: begin
        if (bus.in_flag_last) begin
          if (n_wr_c != '0) begin
            last_ptr_d = wr_ptr + S5_PTR_WIDTH'(n_wr_c) - S5_PTR_WIDTH'(1);
            state_d    = S5_DRAIN;
          end else begin
            state_d = S5_DONE;
          end
        end else if (n_wr_c != '0) begin
          state_d = S5_RUN;
        end
      end
      S5_RUN: begin
        if (bus.in_flag_last) begin
          if (occ_after_c == '0) begin
            state_d = S5_DONE;
          end else begin
            last_ptr_d = wr_ptr + S5_PTR_WIDTH'(n_wr_c) - S5_PTR_WIDTH'(1);
            state_d    = S5_DRAIN;
          end
        end
      end
      S5_DRAIN: begin
        if (pop_c && (rd_ptr == last_ptr_q)) state_d = S5_DONE;
      end
      S5_DONE: begin
        state_d = S5_IDLE;
      end
      default: begin
        state_d = S5_IDLE;
      end
    endcase
  end

  // State, last marker and sticky error flags
  always_ff @(posedge s5_clk) begin
    if (s5_reset) begin
      state_q        <= S5_IDLE;
      last_ptr_q     <= '0;
      out_overflow   <= 1'b0;
      out_flag_error <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_ptr_q <= last_ptr_d;
      if (!fits_c)    out_overflow   <= 1'b1;
      if (flag_bad_c) out_flag_error <= 1'b1;
    end
  end

  assign bus.out_valid   = valid_c;
  assign bus.out_byte    = valid_c ? rd_data : '0;
  assign bus.out_last    = valid_c && (state_q == S5_DRAIN) && (rd_ptr == last_ptr_q);
  assign out_almost_full = occ > S5_OCC_WIDTH'(S5_FIFO_DEPTH - 5);

`ifdef S5_BYTE_COUNTER_EN
  logic done_dly_q;

  // Done trails the DONE state by one cycle so the count is settled; the
  // counter clears right after the pulse and saturates at all-ones
  always_ff @(posedge s5_clk) begin
    if (s5_reset) begin
      done_dly_q      <= 1'b0;
      out_total_bytes <= '0;
    end else begin
      done_dly_q <= (state_q == S5_DONE);
      if (done_dly_q) out_total_bytes <= '0;
      else if (pop_c && (out_total_bytes != '1)) out_total_bytes <= out_total_bytes + 32'd1;
    end
  end

  assign out_done = done_dly_q;
`else
  assign out_done = (state_q == S5_DONE);
`endif

endmodule

// File: tb/tb_stage_5_byte_buffer.sv
// tb_stage_5_byte_buffer: directed plus randomized checks of stage_5_byte_buffer
// against a queue-based frame model.
module tb_stage_5_byte_buffer;
  import stage_5_pkg::*;

  logic s5_clk   = 1'b0;
  logic s5_reset = 1'b1;
  logic out_done, out_almost_full, out_overflow, out_flag_error;
`ifdef S5_BYTE_COUNTER_EN
  logic [31:0] out_total_bytes;
`endif

  stage_5_byte_buffer_if bus ();

  stage_5_byte_buffer dut (
    .s5_clk          (s5_clk),
    .s5_reset        (s5_reset),
    .bus             (bus),
    .out_done        (out_done),
    .out_almost_full (out_almost_full),
    .out_overflow    (out_overflow),
    .out_flag_error  (out_flag_error)
`ifdef S5_BYTE_COUNTER_EN
    ,
    .out_total_bytes (out_total_bytes)
`endif
  );

  always #5 s5_clk = ~s5_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: byte queue, draining-to-last flag, done pulse, sticky errors
  logic [7:0] m_q [$];
  bit m_drain = 1'b0;
  bit m_done  = 1'b0;
  bit m_done_d = 1'b0;
  bit m_ovf   = 1'b0;
  bit m_err   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check outputs at negedge, advance model at posedge
  task automatic do_cycle(input int nf, input bit last, input bit rdy, input bit rst,
                          input logic [39:0] bytes);
    bit exp_v;
    bit exp_done;
    bit pop;
    logic [7:0] exp_b;
    int n;
    bus.in_bit_1          = bytes[7:0];
    bus.in_bit_2          = bytes[15:8];
    bus.in_bit_3          = bytes[23:16];
    bus.in_bit_4          = bytes[31:24];
    bus.in_bit_5          = bytes[39:32];
    bus.in_flag_bitstream = 3'(nf);
    bus.in_flag_last      = last;
    bus.in_ready          = rdy;
    s5_reset              = rst;
    @(negedge s5_clk);
    exp_v = (m_q.size() != 0) && !m_done;
    exp_b = exp_v ? m_q[0] : 8'h00;
`ifdef S5_BYTE_COUNTER_EN
    exp_done = m_done_d;
`else
    exp_done = m_done;
`endif
    check_eq("valid", 32'(bus.out_valid), 32'(exp_v));
    check_eq("byte",  32'(bus.out_byte),  32'(exp_b));
    check_eq("last",  32'(bus.out_last),  32'(exp_v && m_drain && (m_q.size() == 1)));
    check_eq("done",  32'(out_done),      32'(exp_done));
    check_eq("afull", 32'(out_almost_full), 32'(m_q.size() > 27));
    check_eq("ovf",   32'(out_overflow),  32'(m_ovf));
    check_eq("ferr",  32'(out_flag_error), 32'(m_err));
    pop = exp_v && rdy;
    if (rst) begin
      m_q.delete();
      m_drain  = 1'b0;
      m_done   = 1'b0;
      m_done_d = 1'b0;
      m_ovf    = 1'b0;
      m_err    = 1'b0;
    end else begin
      m_done_d = m_done;
      n = nf;
      if (n > 5) begin
        n = 0;
        m_err = 1'b1;
      end
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_drain) begin
        if (pop) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_drain = 1'b0;
            m_done  = 1'b1;
          end
        end
      end else begin
        if (m_q.size() - int'(pop) + n > 32) begin
          m_ovf = 1'b1;
          n = 0;
        end
        if (pop) void'(m_q.pop_front());
        for (int k = 0; k < n; k++) m_q.push_back(bytes[8*k +: 8]);
        if (last) begin
          if (m_q.size() == 0) m_done = 1'b1;
          else m_drain = 1'b1;
        end
      end
    end
    @(posedge s5_clk);
    #1;
  endtask

  task automatic idle_cycles(input int cnt, input bit rdy);
    for (int i = 0; i < cnt; i++) do_cycle(0, 1'b0, rdy, 1'b0, 40'h0);
  endtask

  task automatic fill_bytes(input int chunks, input logic [7:0] base);
    logic [39:0] b;
    for (int i = 0; i < chunks; i++) begin
      for (int k = 0; k < 5; k++) b[8*k +: 8] = 8'(base + 8'(5*i + k));
      do_cycle(5, 1'b0, 1'b0, 1'b0, b);
    end
  endtask

  initial begin
    int rdy_pct;
    bus.in_bit_1 = '0; bus.in_bit_2 = '0; bus.in_bit_3 = '0;
    bus.in_bit_4 = '0; bus.in_bit_5 = '0;
    bus.in_flag_bitstream = '0; bus.in_flag_last = 1'b0; bus.in_ready = 1'b0;
    repeat (2) @(posedge s5_clk);
    #1;
    do_cycle(0, 1'b0, 1'b0, 1'b1, 40'h0);
    idle_cycles(1, 1'b1);

    // single burst of three bytes
    do_cycle(3, 1'b0, 1'b1, 1'b0, 40'h00_00_C3_B2_A1);
    check_eq("burst_head", 32'(bus.out_byte), 32'h A1);
    idle_cycles(4, 1'b1);

    // backpressure hold then release
    do_cycle(5, 1'b0, 1'b0, 1'b0, 40'hE5_D4_C3_B2_A1);
    idle_cycles(4, 1'b0);
    check_eq("hold_byte", 32'(bus.out_byte), 32'h A1);
    check_eq("hold_valid", 32'(bus.out_valid), 32'h1);
    idle_cycles(6, 1'b1);

    // wrap with simultaneous write and pop
    fill_bytes(6, 8'h10);
    idle_cycles(28, 1'b1);
    do_cycle(5, 1'b0, 1'b1, 1'b0, 40'h85_84_83_82_81);
    idle_cycles(8, 1'b1);

    // overflow drops the whole write, then exactly full is accepted
    do_cycle(0, 1'b0, 1'b0, 1'b1, 40'h0);
    fill_bytes(6, 8'h40);
    do_cycle(5, 1'b0, 1'b0, 1'b0, 40'hFF_FE_FD_FC_FB);
    check_eq("ovf_set", 32'(out_overflow), 32'h1);
    do_cycle(2, 1'b0, 1'b0, 1'b0, 40'h00_00_00_99_98);
    check_eq("full_afull", 32'(out_almost_full), 32'h1);
    idle_cycles(34, 1'b1);

    // last on a two-byte write
    do_cycle(0, 1'b0, 1'b0, 1'b1, 40'h0);
    do_cycle(2, 1'b1, 1'b1, 1'b0, 40'h00_00_00_22_11);
    idle_cycles(4, 1'b1);

    // zero-length last on empty buffer
    do_cycle(0, 1'b1, 1'b1, 1'b0, 40'h0);
`ifndef S5_BYTE_COUNTER_EN
    check_eq("empty_done", 32'(out_done), 32'h1);
`endif
    idle_cycles(3, 1'b1);

    // invalid count
    do_cycle(7, 1'b0, 1'b1, 1'b0, 40'h55_44_33_22_11);
    check_eq("flag_err", 32'(out_flag_error), 32'h1);
    check_eq("flag_nowr", 32'(bus.out_valid), 32'h0);
    idle_cycles(2, 1'b1);

    // reset while draining
    do_cycle(0, 1'b0, 1'b0, 1'b1, 40'h0);
    do_cycle(5, 1'b1, 1'b0, 1'b0, 40'h55_44_33_22_11);
    idle_cycles(2, 1'b1);
    do_cycle(0, 1'b0, 1'b1, 1'b1, 40'h0);
    check_eq("rst_valid", 32'(bus.out_valid), 32'h0);
    idle_cycles(3, 1'b1);

    // randomized traffic
    rdy_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      int r;
      int nf;
      if (i % 200 == 0) rdy_pct = $urandom_range(10, 100);
      r  = $urandom_range(0, 39);
      nf = (r == 0) ? 7 : (r == 1) ? 6 : int'($urandom_range(0, 5));
      do_cycle(nf, $urandom_range(0, 29) == 0, $urandom_range(1, 100) <= rdy_pct,
               $urandom_range(0, 499) == 0, {8'($urandom), $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stage_5_byte_buffer.md
Name: stage_5_byte_buffer

Overview:
- Output stage directly downstream of the carry-propagation stage (stage 4).
- Each cycle it accepts 0–5 finished bitstream bytes plus a valid-count flag and a last flag, and stores them in a circular byte buffer.
- It drains the buffer one byte per cycle to the bitstream sink over a valid/ready handshake.
- It marks the final byte of the frame and signals frame completion.

Parameters:
- S5_BITSTREAM_WIDTH, 8, width of one bitstream byte.
- S5_FIFO_DEPTH, 32, buffer capacity in bytes; power of two, at least 8.
- S5_PTR_WIDTH, 5, log2(S5_FIFO_DEPTH).

Ports:
- s5_clk  in  1  single clock.
- s5_reset  in  1  synchronous, active-high reset.
- in_bit_1..in_bit_5  in  S5_BITSTREAM_WIDTH each  bytes from stage 4; in_bit_1 is the oldest in the stream.
- in_flag_bitstream  in  3  number of valid bytes this cycle (0–5), taken from in_bit_1 upward.
- in_flag_last  in  1  stage 4 final indication; the bytes in this cycle (if any) are the last of the frame.
- out_byte  out  S5_BITSTREAM_WIDTH  head byte.
- out_valid  out  1  out_byte is valid.
- in_ready  in  1  sink accepts out_byte this cycle.
- out_last  out  1  out_byte is the final byte of the frame.
- out_done  out  1  one-cycle pulse when the frame is completely drained.
- out_almost_full  out  1  occupancy > S5_FIFO_DEPTH-5.
- out_overflow  out  1  sticky overflow error.
- out_flag_error  out  1  sticky; in_flag_bitstream was 6 or 7.

Behaviour:
- Reset: all outputs 0; pointers and occupancy 0; state IDLE; last-marker cleared. Reset mid-frame discards buffered data, with no out_done.
- Storage: mem[DEPTH], wr_ptr, rd_ptr, occupancy counter (PTR_WIDTH+1 bits). Pointers wrap modulo DEPTH.
- Write: n = in_flag_bitstream. Byte k (k=1..n) goes to mem[wr_ptr+k-1]; wr_ptr += n.
- Invalid count: n = 6 or 7 is treated as 0 and sets out_flag_error.
- Pop: occurs when out_valid && in_ready; rd_ptr += 1.
- Simultaneous write and pop in one cycle: legal. occupancy_next = occupancy + n − pop.
- Overflow: if occupancy − pop + n > DEPTH, the whole write is dropped (no partial write) and out_overflow is set. The pop still proceeds.
- Exactly full (occupancy_next == DEPTH) is legal.
- out_byte = mem[rd_ptr]; out_valid = (occupancy != 0) && state != DONE.
- Latency: a byte written into an empty buffer at edge t is visible at out_byte/out_valid after edge t.
- Holding: out_byte is stable while out_valid && !in_ready.
- State machine:
  - IDLE: buffer empty, no data yet. Go to RUN on the first write with n > 0.
  - RUN: on in_flag_last, record last_ptr = wr_ptr + n − 1 (or wr_ptr − 1 if n = 0), then go to DRAIN.
    - If in_flag_last arrives while occupancy_next == 0 (zero-length tail on an empty buffer), go directly to DONE.
  - DRAIN: further writes are ignored. out_last = out_valid && rd_ptr == last_ptr. The pop of that byte goes to DONE.
  - DONE: out_done high for exactly one cycle, then go to IDLE. A frame can restart in IDLE.
- in_flag_last in IDLE with n > 0: record last_ptr and go straight to DRAIN.

Optional Feature:
- Macro: S5_BYTE_COUNTER_EN.
- When defined:
  - Adds output port out_total_bytes (32 bits) counting popped bytes since reset or since the last out_done. It clears in the cycle after out_done and saturates at 0xFFFFFFFF.
  - out_done is delayed so it coincides with a stable final count.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package stage_5_pkg holds:
  - state encoding localparams (IDLE, RUN, DRAIN, DONE);
  - MAX_BYTES_PER_CYCLE = 5;
  - flag-width constant 3.
- One natural sub-module: s5_byte_ring, containing the memory, pointers, occupancy counter and multi-byte write logic.
- The top level holds the FSM, the last/done logic and the error flags.

Test Plan:
- Single burst: one cycle with n=3, bytes 0xA1 0xB2 0xC3, in_ready=1 → out_byte 0xA1, 0xB2, 0xC3 on three consecutive cycles, then out_valid=0.
- Backpressure: 5 bytes written, in_ready held 0 for 4 cycles → out_byte stays 0xA1 and out_valid stays 1; after release, all 5 bytes emerge in order.
- Wrap and simultaneous: DEPTH=32; fill 30 bytes, pop 28, then write 5 while popping → order is preserved across the wrap and occupancy=6.
- Overflow: occupancy 30, write n=5 with no pop → write dropped, out_overflow=1, occupancy stays 30, existing data intact.
- Last handling:
  - n=2 with in_flag_last → out_last high on the second byte only; out_done pulses the cycle after it pops.
  - n=0 with in_flag_last on an empty buffer → out_done one cycle later.
- Error and reset:
  - in_flag_bitstream=7 → nothing is written and out_flag_error=1.
  - s5_reset mid-DRAIN → all outputs 0 the next cycle and no out_done.
